cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. It generalises the team's 4-bit combinational CLA to WIDTH bits, split into STAGES registered slices. Each slice uses BLOCK-bit lookahead groups, and the carry is registered between slices. It sits in the datapath wherever a wide add/sub must close timing at full clock rate, accepting one operation per cycle under back-pressure.

## Interface
- WIDTH, 16: operand and result width; must be divisible by STAGES*BLOCK.
- STAGES, 2: pipeline register stages, ≥1; each stage computes WIDTH/STAGES bits.
- BLOCK, 4: lookahead group size inside a slice (P/G generate, group carry).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  adder can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: A−B (B inverted, carry-in forced to 1); 0: A+B+cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Slice s (0 = LSB) handles bits [s*W/S +: W/S]. Stage 1 computes slice 0 from a, b, cin/sub. Stage k computes slice k−1 from delayed operand bits and the carry registered by stage k−1.
- Operand bits for upper slices, the sub flag, and completed lower sum bits travel alongside in pipeline registers. No value is ever recomputed.
- Inside a slice: p=a^b', g=a&b', where b'=b^{WIDTH{sub}}. Group carries come from lookahead within each BLOCK. Group-to-group carry inside a slice may ripple. Result must be bit-exact to (a + b' + c0) mod 2^WIDTH.
- ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), evaluated in the last stage on raw (unsaturated) sum.
- Flow control: advance = !out_valid || out_ready; in_ready = advance. All stages shift together on advance. Per-stage valid bits propagate, so bubbles occupy slots and are not collapsed.
- When advance=0, every stage register, including sum/cout/ovf/out_valid, holds.
- A beat is transferred in when in_valid && in_ready, and out when out_valid && out_ready.

## Timing
- Reset (rst high at a rising edge): all stage valid bits cleared. sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 on the cycle after reset.
- Reset mid-operation discards all in-flight beats with no partial outputs. Reset takes priority over advance.
- Latency: a beat accepted at edge k presents on out_valid/sum after edge k+STAGES−1. With continuous out_ready, it transfers at edge k+STAGES.
- Throughput: one beat per cycle with out_ready held high.
- Simultaneous output transfer and input acceptance in the same cycle is legal when the pipeline is full and out_ready=1; no bubble is inserted.
- in_ready is combinational from out_ready and out_valid only. There is no path from in_valid to in_ready.
- Outputs are registered and stable while out_valid && !out_ready.

## Configuration
- CLA_PIPE_SAT_EN defined: the last stage saturates on signed overflow. A positive overflow gives sum = 0x7F..F and a negative overflow gives sum = 0x80..0. ovf still reports 1 and cout reports the raw carry.
- Not defined: sum wraps modulo 2^WIDTH. No saturation logic is present.

## Test plan
- WIDTH=16, STAGES=2, BLOCK=4, no macro. a=0x00FF, b=0x0001, cin=0, sub=0 → sum=0x0100, cout=0, ovf=0, out_valid exactly 2 edges after acceptance. This exercises the inter-slice carry.
- a=0xFFFF, b=0x0001, cin=1, sub=0 → sum=0x0001, cout=1, ovf=0. Then sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 → ovf=1 and sum=0x8000 without the macro. With CLA_PIPE_SAT_EN: sum=0x7FFF, ovf=1. Also a=0x8000, b=0x0001, sub=1 → saturated sum=0x8000 and ovf=1.
- Stream 8 random beats back-to-back, hold out_ready=0 for 3 cycles mid-stream, then release. Required: in_ready drops, held outputs do not change, no beat is lost or duplicated, results match the model in order.
- Fill the pipeline, assert rst for 1 cycle → out_valid=0, sum=0 the next cycle, and no stale beats appear afterwards.
- Repeat the random stream with STAGES=1, and with WIDTH=32, STAGES=4, BLOCK=4 → latency equals STAGES and all results are bit-exact.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined WIDTH-bit carry-lookahead adder/subtractor with a valid/ready
//   stream interface. The operand is cut into STAGES slices of WIDTH/STAGES
//   bits. Each slice is built from BLOCK-bit lookahead groups whose carries
//   ripple from group to group. The carry is registered between slices.
//
//   Optional build macro:
//     CLA_PIPE_SAT_EN  the last stage saturates sum on signed overflow
//                      (0x7F..F for positive, 0x80..0 for negative overflow).
//                      When it is undefined, sum wraps modulo 2^WIDTH.
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     in_valid   operand beat valid
//     in_ready   a beat can be accepted this cycle (= !out_valid || out_ready)
//     a, b       operands [WIDTH-1:0]
//     cin        carry-in, ignored when sub=1
//     sub        1: a-b, 0: a+b+cin
//     out_valid  result beat valid
//     out_ready  downstream accepts the result
//     sum        result [WIDTH-1:0]
//     cout       carry out of the MSB (for sub: 1 = no borrow)
//     ovf        two's-complement signed overflow
//
//   Parameters: WIDTH (divisible by STAGES*BLOCK), STAGES (>=1), BLOCK.
//   Latency: a beat accepted at edge k is presented after edge k+STAGES-1.

module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;  // bits per slice
  localparam int NG = SW / BLOCK;      // lookahead groups per slice
  localparam int L  = STAGES - 1;      // index of the last stage

  // One slice: lookahead carries inside each BLOCK-bit group, ripple
  // between groups. Returns {carry out, slice sum}.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [SW-1:0] p, g, c;
    logic [NG:0]   gc;
    logic          cj, pp;
    p     = x ^ y;
    g     = x & y;
    c     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int unsigned j = 0; j < NG; j++) begin
      // k == BLOCK yields the group carry out (group G | group P & cin).
      for (int unsigned k = 0; k <= BLOCK; k++) begin
        cj = 1'b0;
        pp = 1'b1;
        // Sum of products: g[m-1] & p[k-1:m] for each m, then P & cin.
        for (int unsigned m = k; m > 0; m--) begin
          cj = cj | (pp & g[j*BLOCK + m - 1]);
          pp = pp & p[j*BLOCK + m - 1];
        end
        cj = cj | (pp & gc[j]);
        if (k < BLOCK) c[j*BLOCK + k] = cj;
        else           gc[j+1]        = cj;
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  // Pipeline registers. Operand registers hold the still-unused upper bits
  // shifted down, so the low SW bits are always the next slice's inputs.
  // The completed-sum register shifts right by SW per stage with each new
  // slice entering at the top; after the last stage it is bit-aligned.
  logic [STAGES-1:0] vr;
  logic [WIDTH-1:0]  ar [STAGES];
  logic [WIDTH-1:0]  br [STAGES];
  logic [WIDTH-1:0]  sr [STAGES];
  logic              cr [STAGES];

  // Per-stage combinational inputs and results.
  logic [WIDTH-1:0]  xa [STAGES];
  logic [WIDTH-1:0]  xb [STAGES];
  logic              xc [STAGES];
  logic              xv [STAGES];
  logic [SW:0]       so [STAGES];
  logic [WIDTH-1:0]  ns [STAGES];

  logic              adv;
  logic              ovf_n;
  logic [WIDTH-1:0]  sum_n;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vr[L];

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    if (s == 0) begin : g_src
      assign xa[s] = a;
      assign xb[s] = b ^ {WIDTH{sub}};
      assign xc[s] = sub | cin;
      assign xv[s] = in_valid;
      assign ns[s] = WIDTH'({so[s][SW-1:0], {WIDTH{1'b0}}} >> SW);
    end else begin : g_src
      assign xa[s] = ar[s-1];
      assign xb[s] = br[s-1];
      assign xc[s] = cr[s-1];
      assign xv[s] = vr[s-1];
      assign ns[s] = WIDTH'({so[s][SW-1:0], sr[s-1]} >> SW);
    end
    assign so[s] = slice_add(xa[s][SW-1:0], xb[s][SW-1:0], xc[s]);
  end

  // The last slice sees the operand MSBs, so overflow is decided there on
  // the raw sum.
  assign ovf_n = (xa[L][SW-1] == xb[L][SW-1]) && (so[L][SW-1] != xa[L][SW-1]);

`ifdef CLA_PIPE_SAT_EN
  always_comb begin
    sum_n = ns[L];
    if (ovf_n)
      sum_n = xa[L][SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_n = ns[L];
`endif

  // Datapath stage registers load only for valid beats; bubbles leave them
  // untouched since the valid bits alone mark occupancy.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (adv && xv[s]) begin
        ar[s] <= xa[s] >> SW;
        br[s] <= xb[s] >> SW;
        cr[s] <= so[s][SW];
        sr[s] <= ns[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vr   <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (adv) begin
      for (int unsigned s = 0; s < STAGES; s++)
        vr[s] <= xv[s];
      if (xv[L]) begin
        sum  <= sum_n;
        cout <= so[L][SW];
        ovf  <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder. Three instances share the stream controls:
//   u0: WIDTH=16 STAGES=2 BLOCK=4  (a[15:0], b[15:0])
//   u1: WIDTH=16 STAGES=1 BLOCK=4  (a[15:0], b[15:0])
//   u2: WIDTH=32 STAGES=4 BLOCK=4  (a, b)
// Build with +define+CLA_PIPE_SAT_EN to check the saturating variant.

module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, cin, sub;
  logic [31:0] a, b;

  logic        rdy0, vld0, co0, ov0;
  logic [15:0] s0;
  logic        rdy1, vld1, co1, ov1;
  logic [15:0] s1;
  logic        rdy2, vld2, co2, ov2;
  logic [31:0] s2;

  int tests = 0;
  int fails = 0;

  cla_pipe_adder #(.WIDTH(16), .STAGES(2), .BLOCK(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(vld0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(ov0));

  cla_pipe_adder #(.WIDTH(16), .STAGES(1), .BLOCK(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(vld1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(ov1));

  cla_pipe_adder #(.WIDTH(32), .STAGES(4), .BLOCK(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(vld2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(ov2));

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic ci, input logic su);
    logic [31:0] m, xm, ym, r;
    logic [32:0] t;
    logic        co, ov, am, bm;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    xm = x & m;
    ym = (su ? ~y : y) & m;
    t  = {1'b0, xm} + {1'b0, ym} + {32'h0, (su | ci)};
    co = t[w];
    r  = t[31:0] & m;
    am = xm[w-1];
    bm = ym[w-1];
    ov = (am == bm) && (r[w-1] != am);
`ifdef CLA_PIPE_SAT_EN
    if (ov) r = am ? (32'h1 << (w-1)) : (m >> 1);
`endif
    return {ov, co, r};
  endfunction

  // Captured first result of a single beat, per instance.
  int          lat [3];
  int          nv  [3];
  logic [31:0] rs  [3];
  logic        rc  [3];
  logic        ro  [3];

  // Drives one beat, then watches 8 cycles. lat = edges after the
  // acceptance edge before out_valid was seen; nv = cycles it was high.
  task automatic send_one(input logic [31:0] va, input logic [31:0] vb,
                          input logic vc, input logic vs);
    @(negedge clk);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; nv[i] = 0; end
    for (int n = 0; n < 8; n++) begin
      if (vld0) begin
        nv[0]++;
        if (lat[0] < 0) begin lat[0] = n; rs[0] = {16'h0, s0}; rc[0] = co0; ro[0] = ov0; end
      end
      if (vld1) begin
        nv[1]++;
        if (lat[1] < 0) begin lat[1] = n; rs[1] = {16'h0, s1}; rc[1] = co1; ro[1] = ov1; end
      end
      if (vld2) begin
        nv[2]++;
        if (lat[2] < 0) begin lat[2] = n; rs[2] = s2; rc[2] = co2; ro[2] = ov2; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({vld0, co0, ov0, s0} !== 19'h0 || rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_u0: vld=%b cout=%b ovf=%b sum=%h rdy=%b, want 0 0 0 0000 1",
               vld0, co0, ov0, s0, rdy0);
    end
    tests++;
    if ({vld1, co1, ov1, s1} !== 19'h0 || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_u1: vld=%b cout=%b ovf=%b sum=%h rdy=%b, want 0 0 0 0000 1",
               vld1, co1, ov1, s1, rdy1);
    end
    tests++;
    if ({vld2, co2, ov2, s2} !== 35'h0 || rdy2 !== 1'b1) begin
      fails++;
      $display("FAIL reset_u2: vld=%b cout=%b ovf=%b sum=%h rdy=%b, want 0 0 0 00000000 1",
               vld2, co2, ov2, s2, rdy2);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_carry;
    send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    tests++;
    if (rs[0] !== 32'h0100 || rc[0] !== 1'b0 || ro[0] !== 1'b0) begin
      fails++; $display("FAIL add_carry_u0: sum=%h cout=%b ovf=%b, want 0100 0 0", rs[0], rc[0], ro[0]);
    end
    tests++;
    if (rs[1] !== 32'h0100 || rc[1] !== 1'b0 || ro[1] !== 1'b0) begin
      fails++; $display("FAIL add_carry_u1: sum=%h cout=%b ovf=%b, want 0100 0 0", rs[1], rc[1], ro[1]);
    end
    tests++;
    if (rs[2] !== 32'h0000_0100 || rc[2] !== 1'b0 || ro[2] !== 1'b0) begin
      fails++; $display("FAIL add_carry_u2: sum=%h cout=%b ovf=%b, want 00000100 0 0", rs[2], rc[2], ro[2]);
    end
    tests++;
    if (lat[0] !== 1 || nv[0] !== 1) begin
      fails++; $display("FAIL latency_u0: lat=%0d beats=%0d, want 1 1", lat[0], nv[0]);
    end
    tests++;
    if (lat[1] !== 0 || nv[1] !== 1) begin
      fails++; $display("FAIL latency_u1: lat=%0d beats=%0d, want 0 1", lat[1], nv[1]);
    end
    tests++;
    if (lat[2] !== 3 || nv[2] !== 1) begin
      fails++; $display("FAIL latency_u2: lat=%0d beats=%0d, want 3 1", lat[2], nv[2]);
    end
  endtask

  task automatic test_cin_wrap;
    send_one(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    tests++;
    if (rs[0] !== 32'h0001 || rc[0] !== 1'b1 || ro[0] !== 1'b0) begin
      fails++; $display("FAIL cin_wrap_u0: sum=%h cout=%b ovf=%b, want 0001 1 0", rs[0], rc[0], ro[0]);
    end
    tests++;
    if (rs[1] !== 32'h0001 || rc[1] !== 1'b1 || ro[1] !== 1'b0) begin
      fails++; $display("FAIL cin_wrap_u1: sum=%h cout=%b ovf=%b, want 0001 1 0", rs[1], rc[1], ro[1]);
    end
    tests++;
    if (rs[2] !== 32'h0001_0001 || rc[2] !== 1'b0 || ro[2] !== 1'b0) begin
      fails++; $display("FAIL cin_wrap_u2: sum=%h cout=%b ovf=%b, want 00010001 0 0", rs[2], rc[2], ro[2]);
    end
  endtask

  // cin is held at 1 here to confirm it is ignored during subtraction.
  task automatic test_sub;
    send_one(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    tests++;
    if (rs[0] !== 32'hFFFE || rc[0] !== 1'b0 || ro[0] !== 1'b0) begin
      fails++; $display("FAIL sub_u0: sum=%h cout=%b ovf=%b, want fffe 0 0", rs[0], rc[0], ro[0]);
    end
    tests++;
    if (rs[1] !== 32'hFFFE || rc[1] !== 1'b0 || ro[1] !== 1'b0) begin
      fails++; $display("FAIL sub_u1: sum=%h cout=%b ovf=%b, want fffe 0 0", rs[1], rc[1], ro[1]);
    end
    tests++;
    if (rs[2] !== 32'hFFFF_FFFE || rc[2] !== 1'b0 || ro[2] !== 1'b0) begin
      fails++; $display("FAIL sub_u2: sum=%h cout=%b ovf=%b, want fffffffe 0 0", rs[2], rc[2], ro[2]);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] pos_sum, neg_sum;
`ifdef CLA_PIPE_SAT_EN
    pos_sum = 32'h7FFF; neg_sum = 32'h8000;
`else
    pos_sum = 32'h8000; neg_sum = 32'h7FFF;
`endif
    // 0x7FFF + 1: positive overflow (16-bit), plain add at 32 bits.
    send_one(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    tests++;
    if (rs[0] !== pos_sum || rc[0] !== 1'b0 || ro[0] !== 1'b1) begin
      fails++; $display("FAIL ovf_pos_u0: sum=%h cout=%b ovf=%b, want %h 0 1", rs[0], rc[0], ro[0], pos_sum);
    end
    tests++;
    if (rs[1] !== pos_sum || rc[1] !== 1'b0 || ro[1] !== 1'b1) begin
      fails++; $display("FAIL ovf_pos_u1: sum=%h cout=%b ovf=%b, want %h 0 1", rs[1], rc[1], ro[1], pos_sum);
    end
    tests++;
    if (rs[2] !== 32'h0000_8000 || rc[2] !== 1'b0 || ro[2] !== 1'b0) begin
      fails++; $display("FAIL ovf_pos_u2: sum=%h cout=%b ovf=%b, want 00008000 0 0", rs[2], rc[2], ro[2]);
    end
    // 0x8000 - 1: negative overflow (16-bit), no borrow so cout=1.
    send_one(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
    tests++;
    if (rs[0] !== neg_sum || rc[0] !== 1'b1 || ro[0] !== 1'b1) begin
      fails++; $display("FAIL ovf_neg_u0: sum=%h cout=%b ovf=%b, want %h 1 1", rs[0], rc[0], ro[0], neg_sum);
    end
    tests++;
    if (rs[1] !== neg_sum || rc[1] !== 1'b1 || ro[1] !== 1'b1) begin
      fails++; $display("FAIL ovf_neg_u1: sum=%h cout=%b ovf=%b, want %h 1 1", rs[1], rc[1], ro[1], neg_sum);
    end
    tests++;
    if (rs[2] !== 32'h0000_7FFF || rc[2] !== 1'b1 || ro[2] !== 1'b0) begin
      fails++; $display("FAIL ovf_neg_u2: sum=%h cout=%b ovf=%b, want 00007fff 1 0", rs[2], rc[2], ro[2]);
    end
  endtask

  // 8 beats back to back, out_ready low for cycles 4..6.
  task automatic test_back_to_back;
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [33:0] q0 [$];
    logic [33:0] q1 [$];
    logic [33:0] q2 [$];
    logic [33:0] e;
    logic [18:0] snap;
    int          idx;
    int          got [3];
    idx = 0;
    snap = '0;
    for (int i = 0; i < 3; i++) got[i] = 0;
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom(); vb[i] = $urandom();
      vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
    end
    va[2] = 32'h7FFF_7FFF; vb[2] = 32'h0000_0001; vs[2] = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (idx < 8);
      if (idx < 8) begin a = va[idx]; b = vb[idx]; cin = vc[idx]; sub = vs[idx]; end
      #1;
      if (cyc == 4) snap = {vld0, ov0, co0, s0};
      if (cyc >= 4 && cyc < 7) begin
        tests++;
        if (rdy0 !== 1'b0) begin
          fails++; $display("FAIL stall_ready cyc%0d: in_ready=%b, want 0", cyc, rdy0);
        end
      end
      if (cyc >= 5 && cyc <= 7) begin
        tests++;
        if ({vld0, ov0, co0, s0} !== snap) begin
          fails++; $display("FAIL stall_hold cyc%0d: out=%h, want %h", cyc, {vld0, ov0, co0, s0}, snap);
        end
      end
      if (vld0 && out_ready) begin
        got[0]++; tests++;
        e = (q0.size() > 0) ? q0.pop_front() : 34'h3_FFFF_FFFF;
        if ({ov0, co0, s0} !== {e[33], e[32], e[15:0]}) begin
          fails++; $display("FAIL stream_u0 #%0d: %b %b %h, want %b %b %h", got[0], ov0, co0, s0, e[33], e[32], e[15:0]);
        end
      end
      if (vld1 && out_ready) begin
        got[1]++; tests++;
        e = (q1.size() > 0) ? q1.pop_front() : 34'h3_FFFF_FFFF;
        if ({ov1, co1, s1} !== {e[33], e[32], e[15:0]}) begin
          fails++; $display("FAIL stream_u1 #%0d: %b %b %h, want %b %b %h", got[1], ov1, co1, s1, e[33], e[32], e[15:0]);
        end
      end
      if (vld2 && out_ready) begin
        got[2]++; tests++;
        e = (q2.size() > 0) ? q2.pop_front() : 34'h3_FFFF_FFFF;
        if ({ov2, co2, s2} !== e) begin
          fails++; $display("FAIL stream_u2 #%0d: %b %b %h, want %b %b %h", got[2], ov2, co2, s2, e[33], e[32], e[31:0]);
        end
      end
      if (in_valid && rdy0) q0.push_back(model(16, a, b, cin, sub));
      if (in_valid && rdy1) q1.push_back(model(16, a, b, cin, sub));
      if (in_valid && rdy2) q2.push_back(model(32, a, b, cin, sub));
      if (in_valid && rdy0) idx++;
    end
    in_valid = 1'b0;
    tests++;
    if (got[0] !== 8 || q0.size() !== 0) begin
      fails++; $display("FAIL stream_count_u0: out=%0d left=%0d, want 8 0", got[0], q0.size());
    end
    tests++;
    if (got[1] !== 8 || q1.size() !== 0) begin
      fails++; $display("FAIL stream_count_u1: out=%0d left=%0d, want 8 0", got[1], q1.size());
    end
    tests++;
    if (got[2] !== 8 || q2.size() !== 0) begin
      fails++; $display("FAIL stream_count_u2: out=%0d left=%0d, want 8 0", got[2], q2.size());
    end
  endtask

  // Fill all pipelines under back-pressure, then reset for one cycle with
  // in_valid still high: everything in flight must vanish.
  task automatic test_reset_flush;
    int stale;
    stale = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    tests++;
    if ({vld0, vld1, vld2} !== 3'b000 || s0 !== 16'h0 || s1 !== 16'h0 || s2 !== 32'h0) begin
      fails++;
      $display("FAIL flush_clear: vld=%b%b%b sum=%h %h %h, want 000 0 0 0", vld0, vld1, vld2, s0, s1, s2);
    end
    tests++;
    if ({rdy0, rdy1, rdy2} !== 3'b111) begin
      fails++; $display("FAIL flush_ready: in_ready=%b%b%b, want 111", rdy0, rdy1, rdy2);
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (vld0 || vld1 || vld2) stale++;
    end
    tests++;
    if (stale !== 0) begin
      fails++; $display("FAIL flush_stale: stale cycles=%0d, want 0", stale);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_carry();
    test_cin_wrap();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
